reg_file_32x32: RTL

- General-purpose register file for the single-cycle KGP-RISC datapath.
- Sits directly downstream of the 32-bit writeback 2:1 select, which chooses between ALU result and data-memory read. It consumes that selected word as `wr_data`.
- Also feeds the ALU operand path through two read ports.
- Register 0 is hardwired to zero. Writes are synchronous. A write-to-read bypass keeps same-cycle reads coherent.

---
 rtl/reg_file_32x32.sv | 70 +++++++
 1 files changed

// File: rtl/reg_file_32x32.sv
// General-purpose register file for the KGP-RISC datapath: two combinational read ports with
// write-to-read bypass, one synchronous write port, a debug read port and a saturating write counter.
module reg_file_32x32 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [15:0]       wr_count_q;
    logic              wr_commit;

    assign wr_commit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (wr_commit) begin
            regs_q[wr_addr] <= wr_data;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    // Bypass is suppressed during reset because the pending write will be dropped.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        dbg_data  = '0;
        if (rd_addr_a != '0) begin
            if (BYPASS && !rst && wr_en && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs_q[rd_addr_a];
            end
        end
        if (rd_addr_b != '0) begin
            if (BYPASS && !rst && wr_en && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs_q[rd_addr_b];
            end
        end
        if (dbg_addr != '0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    assign wr_count = wr_count_q;

endmodule
